// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame loader.
package uart_pkg;

  typedef enum logic [2:0] {
    SYNC,
    CMD,
    ADDR_H,
    ADDR_L,
    LEN_H,
    LEN_L,
    DATA,
    CSUM
  } loader_state_t;

  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_RUN      = 8'h02;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: flags when no byte has arrived for TIMEOUT_CLKS-1 cycles
// while a frame is open.
module uart_gap_timer #(
  parameter int TIMEOUT_CLKS = 262144
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] timer;

  // Saturates at LAST so an unserviced expiry cannot wrap back to a quiet count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (clear || !enable) begin
      timer <= '0;
    end else if (timer != LAST) begin
      timer <= timer + 1'b1;
    end
  end

  assign expired = enable && (timer == LAST);

endmodule

// File: rtl/uart_loader.sv
// Host frame parser: decodes A5-framed WRITE/RUN commands from the UART byte
// stream, writes payloads to memory and controls the CPU reset hold.
module uart_loader
  import uart_pkg::*;
#(
  parameter int          TIMEOUT_CLKS = 262144,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  loader_state_t state;
  logic [7:0]    sum;
  logic [7:0]    next_sum;
  logic          is_run;
  logic [15:0]   addr;
  logic [7:0]    len_h;
  logic [15:0]   len_full;
  logic [15:0]   count;
  logic          expired;

  assign next_sum = sum + rx_data;
  assign len_full = {len_h, rx_data};
  assign busy     = (state != SYNC);

  uart_gap_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_valid),
    .enable (busy),
    .expired(expired)
  );

  // A received byte always takes priority over a timeout in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SYNC;
      sum       <= '0;
      is_run    <= 1'b0;
      addr      <= '0;
      len_h     <= '0;
      count     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      if (rx_valid) begin
        if (state != SYNC) begin
          sum <= next_sum;
        end
        case (state)
          SYNC: begin
            if (rx_data == SYNC_BYTE) begin
              state <= CMD;
              sum   <= '0;
            end
          end
          CMD: begin
            if (rx_data == CMD_WRITE) begin
              is_run   <= 1'b0;
              cpu_hold <= 1'b1;
              state    <= ADDR_H;
            end else if (rx_data == CMD_RUN) begin
              is_run <= 1'b1;
              state  <= ADDR_H;
            end else begin
              err   <= 1'b1;
              state <= SYNC;
            end
          end
          ADDR_H: begin
            addr[15:8] <= rx_data;
            state      <= ADDR_L;
          end
          ADDR_L: begin
            addr[7:0] <= rx_data;
            state     <= LEN_H;
          end
          LEN_H: begin
            len_h <= rx_data;
            state <= LEN_L;
          end
          LEN_L: begin
            count <= len_full;
            if (is_run && (len_full != 16'h0000)) begin
              err   <= 1'b1;
              state <= SYNC;
            end else if (len_full == 16'h0000) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= rx_data;
            addr      <= addr + 16'h0001;
            count     <= count - 16'h0001;
            if (count == 16'h0001) begin
              state <= CSUM;
            end
          end
          CSUM: begin
            if (next_sum == 8'h00) begin
              done <= 1'b1;
              if (is_run) begin
                cpu_hold <= 1'b0;
              end
            end else begin
              err <= 1'b1;
            end
            state <= SYNC;
          end
          default: state <= SYNC;
        endcase
      end else if (expired) begin
        err   <= 1'b1;
        state <= SYNC;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Randomized self-checking bench for uart_loader against a frame-level model.
module tb_uart_loader;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  uart_loader #(
    .TIMEOUT_CLKS(TO),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [23:0] got_wr[$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  logic        hold_at_done = 1'b1;
  logic        exp_hold = 1'b1;
  logic [7:0]  payload_q[$];

  // Observes one-cycle strobes just after each active edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (mem_we) got_wr.push_back({mem_addr, mem_wdata});
      if (done) begin
        done_cnt++;
        hold_at_done = cpu_hold;
      end
      if (err) err_cnt++;
      if (done && err) both_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clearObs();
    got_wr.delete();
    done_cnt = 0;
    err_cnt  = 0;
    both_cnt = 0;
  endtask

  // Called at a negedge; the byte is sampled on the next posedge.
  task automatic sendByte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Builds a frame, predicts its effect from the frame rules, sends it and compares.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [15:0] addr,
                               input logic [7:0] csum_delta, input int junk, input string name);
    logic [7:0]  bytes_q[$];
    logic [23:0] exp_wr[$];
    logic [15:0] len16;
    logic [15:0] wa;
    logic [7:0]  j;
    logic [7:0]  csum;
    int          tot;
    int          exp_done;
    int          exp_err;
    len16    = 16'(payload_q.size());
    exp_done = 0;
    exp_err  = 0;
    for (int i = 0; i < junk; i++) begin
      j = 8'($urandom_range(0, 255));
      if (j == 8'hA5) j = 8'h5A;
      bytes_q.push_back(j);
    end
    bytes_q.push_back(8'hA5);
    bytes_q.push_back(cmd);
    if (cmd != 8'h01 && cmd != 8'h02) begin
      exp_err = 1;
    end else begin
      if (cmd == 8'h01) exp_hold = 1'b1;
      bytes_q.push_back(addr[15:8]);
      bytes_q.push_back(addr[7:0]);
      bytes_q.push_back(len16[15:8]);
      bytes_q.push_back(len16[7:0]);
      if (cmd == 8'h02 && len16 != 16'h0000) begin
        exp_err = 1;
      end else begin
        tot = int'(cmd) + int'(addr[15:8]) + int'(addr[7:0]) + int'(len16[15:8]) + int'(len16[7:0]);
        for (int i = 0; i < payload_q.size(); i++) begin
          bytes_q.push_back(payload_q[i]);
          tot += int'(payload_q[i]);
          wa = addr + 16'(i);
          exp_wr.push_back({wa, payload_q[i]});
        end
        csum = 8'((256 - (tot % 256)) % 256) + csum_delta;
        bytes_q.push_back(csum);
        if (csum_delta == 8'h00) begin
          exp_done = 1;
          if (cmd == 8'h02) exp_hold = 1'b0;
        end else begin
          exp_err = 1;
        end
      end
    end
    foreach (bytes_q[i]) sendByte(bytes_q[i], $urandom_range(0, 3));
    repeat (3) @(negedge clk);
    checkOutput({name, "_wcount"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      checkOutput($sformatf("%s_wr%0d", name, i), got_wr[i], exp_wr[i]);
    checkOutput({name, "_done"}, done_cnt, exp_done);
    checkOutput({name, "_err"}, err_cnt, exp_err);
    checkOutput({name, "_both"}, both_cnt, 0);
    checkOutput({name, "_hold"}, cpu_hold, exp_hold);
    checkOutput({name, "_busy"}, busy, 1'b0);
    if (exp_done == 1) checkOutput({name, "_hold_at_done"}, hold_at_done, exp_hold);
  endtask

  initial begin
    int          r;
    int          n;
    logic [7:0]  cmd;
    logic [7:0]  delta;
    logic [15:0] addr;

    repeat (3) @(negedge clk);
    checkOutput("rst_we", mem_we, 1'b0);
    checkOutput("rst_addr", mem_addr, 16'h0000);
    checkOutput("rst_wdata", mem_wdata, 8'h00);
    checkOutput("rst_hold", cpu_hold, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    payload_q = '{8'h11, 8'h22};
    clearObs();
    applyStimulus(8'h01, 16'h8000, 8'h00, 0, "t1_write");
    clearObs();
    applyStimulus(8'h01, 16'h8000, 8'h01, 0, "t2_badsum");
    payload_q.delete();
    clearObs();
    applyStimulus(8'h02, 16'h0000, 8'h00, 0, "t3_run");

    // Timeout after ADDR_L on a RUN header: hold must stay released.
    clearObs();
    sendByte(8'hA5, 0); sendByte(8'h02, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    repeat (TO - 2) @(negedge clk);
    checkOutput("t6_pre_err", err_cnt, 0);
    checkOutput("t6_pre_busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("t6_err", err_cnt, 1);
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_hold", cpu_hold, exp_hold);

    // Byte lands exactly on the expiry cycle: frame survives.
    clearObs();
    sendByte(8'hA5, 0); sendByte(8'h02, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    sendByte(8'h00, TO - 1);
    sendByte(8'h00, 0); sendByte(8'hFE, 0);
    repeat (3) @(negedge clk);
    checkOutput("t6_edge_err", err_cnt, 0);
    checkOutput("t6_edge_done", done_cnt, 1);

    // One cycle later than that: timeout wins, trailing bytes are junk.
    clearObs();
    sendByte(8'hA5, 0); sendByte(8'h02, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    sendByte(8'h00, TO);
    sendByte(8'h00, 0); sendByte(8'hFE, 0);
    repeat (3) @(negedge clk);
    checkOutput("t6_late_err", err_cnt, 1);
    checkOutput("t6_late_done", done_cnt, 0);
    checkOutput("t6_late_busy", busy, 1'b0);

    clearObs();
    sendByte(8'h00, 1); sendByte(8'hFF, 0); sendByte(8'h3C, 2);
    applyStimulus(8'h07, 16'h0000, 8'h00, 0, "t4_badcmd");
    payload_q = '{8'h11, 8'h22};
    clearObs();
    applyStimulus(8'h01, 16'h8000, 8'h00, 0, "t4_recover");
    payload_q = '{8'hAA, 8'hBB};
    clearObs();
    applyStimulus(8'h01, 16'hFFFF, 8'h00, 0, "t5_wrap");

    for (int f = 0; f < 40; f++) begin
      payload_q.delete();
      r = $urandom_range(0, 99);
      if (r < 55) begin
        cmd = 8'h01;
        n = $urandom_range(0, 8);
        for (int i = 0; i < n; i++) payload_q.push_back(8'($urandom_range(0, 255)));
      end else if (r < 80) begin
        cmd = 8'h02;
      end else if (r < 88) begin
        cmd = 8'h02;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) payload_q.push_back(8'($urandom_range(0, 255)));
      end else begin
        cmd = 8'($urandom_range(3, 255));
      end
      delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      clearObs();
      applyStimulus(cmd, addr, delta, $urandom_range(0, 3), $sformatf("rnd%0d", f));
    end

    // Async reset with a write strobe in flight.
    clearObs();
    sendByte(8'hA5, 0); sendByte(8'h01, 0); sendByte(8'h12, 0); sendByte(8'h34, 0);
    sendByte(8'h00, 0); sendByte(8'h05, 0); sendByte(8'h77, 0);
    checkOutput("rst_mid_inflight", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_we", mem_we, 1'b0);
    checkOutput("rst_mid_busy", busy, 1'b0);
    checkOutput("rst_mid_hold", cpu_hold, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_hold = 1'b1;
    @(negedge clk);
    payload_q = '{8'h11, 8'h22};
    clearObs();
    applyStimulus(8'h01, 16'h8000, 8'h00, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
